// File: rtl/mxpl_pkg.sv
// mxpl_pkg: shared compare helper and sizing functions for the mxpl_stream max-pool slice.
// Revision 1.0
`default_nettype none

package mxpl_pkg;

    // Widest pixel the shared compare supports; callers extend their operands to this width.
    localparam int MAXW = 64;

    function automatic logic [MAXW-1:0] max2(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input logic            sgn
    );
        if (sgn) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

    function automatic int lb_depth(input int img_w);
        return img_w / 2;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mxpl_linebuf.sv
// mxpl_linebuf: one row of horizontal maxima; single write port, asynchronous read on the same index.
// Revision 1.0
`default_nettype none

module mxpl_linebuf #(
    parameter int W  = 8,
    parameter int D  = 6,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    // Not reset: every entry is written on an even row before the odd row reads it.
    logic [W-1:0] r_mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/mxpl_stream.sv
// mxpl_stream: streaming 2x2 stride-2 max-pool with valid/ready and end-of-frame flag.
// Optional macro MXPL_RELU_EN fuses a ReLU after the vertical max (signed mode only). Revision 1.0
`default_nettype none

module mxpl_stream
    import mxpl_pkg::*;
#(
    parameter int W      = 8,
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 12,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int LB_D = lb_depth(IMG_W);
    localparam int AW   = idx_width(LB_D);
    localparam logic SGN = (SIGNED != 0);

    if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_dims
        $error("mxpl_stream: IMG_W and IMG_H must be even and >= 2");
    end
    if ((W < 1) || (W > MAXW)) begin : g_bad_width
        $error("mxpl_stream: W out of supported range");
    end

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [W-1:0]  r_hold;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_lb_we;
    logic          w_load;
    logic [AW-1:0] w_lb_idx;
    logic [W-1:0]  w_lb_rd;
    logic [W-1:0]  w_hmax;
    logic [W-1:0]  w_vmax;
    logic [W-1:0]  w_result;

    function automatic logic [MAXW-1:0] ext(input logic [W-1:0] x);
        if (SGN) begin
            return MAXW'($signed(x));
        end
        return MAXW'(x);
    endfunction

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_lb_idx   = AW'(r_col >> 1);
    assign w_lb_we    = w_accept && r_col[0] && !r_row[0];
    assign w_load     = w_accept && r_col[0] && r_row[0];

    assign w_hmax = W'(max2(ext(r_hold), ext(in_data), SGN));
    assign w_vmax = W'(max2(ext(w_lb_rd), ext(w_hmax), SGN));

`ifdef MXPL_RELU_EN
    assign w_result = (SGN && w_vmax[W-1]) ? '0 : w_vmax;
`else
    assign w_result = w_vmax;
`endif

    mxpl_linebuf #(
        .W  (W),
        .D  (LB_D),
        .AW (AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (w_lb_we),
        .idx   (w_lb_idx),
        .wdata (w_hmax),
        .rdata (w_lb_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
        end else if (w_accept) begin
            if (!r_col[0]) begin
                r_hold <= in_data;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // A load in the same cycle as a pop wins, so the register stays full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_last && w_row_last;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_col != '0) || (r_row != '0) || r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mxpl_stream.sv
// tb_mxpl_stream: directed checks on 4x4 unsigned/signed instances plus a randomized 12x12 run.
// Revision 1.0
`default_nettype none

module tb_mxpl_stream;

    logic       clk = 1'b0;
    logic       rst_s, rst_b, in_valid, out_ready;
    logic [7:0] in_data;

    logic       u_ready, u_valid, u_last, u_busy;
    logic [7:0] u_data;
    logic       s_ready, s_valid, s_last, s_busy;
    logic [7:0] s_data;
    logic       b_ready, b_valid, b_last, b_busy;
    logic [7:0] b_data;

    logic [8:0] q_u[$], q_s[$], q_b[$], exp_q[$];
    logic [7:0] frame_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         big_sel = 1'b0;
    bit         chk_busy = 1'b0;

`ifdef MXPL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    always #5 clk = ~clk;

    mxpl_stream #(.W(8), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(u_ready), .in_data(in_data),
        .out_valid(u_valid), .out_ready(out_ready), .out_data(u_data), .out_last(u_last), .busy(u_busy));

    mxpl_stream #(.W(8), .IMG_W(4), .IMG_H(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
        .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data), .out_last(s_last), .busy(s_busy));

    mxpl_stream #(.W(8), .IMG_W(12), .IMG_H(12), .SIGNED(0)) u_big (
        .clk(clk), .rst(rst_b), .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_last(b_last), .busy(b_busy));

    always @(posedge clk) begin
        if (!rst_s && u_valid && out_ready) q_u.push_back({u_last, u_data});
        if (!rst_s && s_valid && out_ready) q_s.push_back({s_last, s_data});
        if (!rst_b && b_valid && out_ready) q_b.push_back({b_last, b_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [8:0] act[$], input logic [8:0] exp[$]);
        chk({tag, "_count"}, act.size(), exp.size());
        for (int k = 0; k < act.size() && k < exp.size(); k++) begin
            chk($sformatf("%s[%0d]", tag, k), {23'd0, act[k]}, {23'd0, exp[k]});
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", u_valid, 1'b0);
        chk("rst_data", u_data, 8'd0);
        chk("rst_last", u_last, 1'b0);
        chk("rst_busy", u_busy, 1'b0);
        chk("rst_ready", u_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_s = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        q_u.delete(); q_s.delete();
    endtask

    task automatic load_basic();
        logic [7:0] pix [16] = '{1, 5, 2, 0, 3, 4, 9, 7, 8, 8, 0, 1, 2, 6, 3, 255};
        for (int k = 0; k < 16; k++) frame_q.push_back(pix[k]);
    endtask

    // mode 0: always valid/ready; 1: hold out_ready low 5 cycles at first output; 2: random 50%.
    task automatic send(input int mode);
        int i, guard;
        bit stalled, acc, rdy;
        i = 0; guard = 0; stalled = 1'b0;
        while (i < frame_q.size()) begin
            @(negedge clk);
            if (mode == 1 && !stalled && u_valid) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("bp_data", u_data, 8'd5);
                    chk("bp_ready", u_ready, 1'b0);
                    chk("bp_valid", u_valid, 1'b1);
                    @(negedge clk);
                end
            end
            if (mode == 2) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end
            in_data = frame_q[i];
            #1;
            rdy = big_sel ? b_ready : u_ready;
            acc = in_valid && rdy;
            @(posedge clk);
            if (acc) i++;
            #1;
            if (chk_busy) chk("busy_hold", u_busy, 1'b1);
            guard++;
            if (guard > 40 * frame_q.size() + 100) begin
                chk("send_timeout", i, frame_q.size());
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic model(input int w, input int h, input int base);
        logic [7:0] m, v;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                m = frame_q[base + r*w + c];
                v = frame_q[base + r*w + c + 1];     if (v > m) m = v;
                v = frame_q[base + (r+1)*w + c];     if (v > m) m = v;
                v = frame_q[base + (r+1)*w + c + 1]; if (v > m) m = v;
                exp_q.push_back({(r == h-2) && (c == w-2), m});
            end
        end
    endtask

    initial begin
        bit expv;
        logic [7:0] expd;
        rst_s = 1'b1; rst_b = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

        // Reset state and basic frame with per-beat latency checks.
        do_reset();
        chk_reset_state();
        frame_q.delete(); load_basic();
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; in_data = frame_q[p];
            @(posedge clk);
            #1;
            expv = (p == 5) || (p == 7) || (p == 13) || (p == 15);
            expd = (p == 5) ? 8'd5 : (p == 7) ? 8'd9 : (p == 13) ? 8'd8 : 8'd255;
            chk($sformatf("lat_valid_p%0d", p), u_valid, expv);
            if (expv) begin
                chk($sformatf("lat_data_p%0d", p), u_data, expd);
                chk($sformatf("lat_last_p%0d", p), u_last, p == 15);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_q = '{9'h005, 9'h009, 9'h008, 9'h1FF};
        check_q("basic", q_u, exp_q);

        // Backpressure.
        do_reset();
        send(1);
        check_q("bp", q_u, exp_q);

        // Signed all-negative frame.
        do_reset();
        frame_q.delete();
        for (int k = 0; k < 16; k++) frame_q.push_back(8'(8'h80 + k));
        send(0);
        exp_q = '{9'h085, 9'h087, 9'h08D, 9'h18F};
        check_q("neg_uns", q_u, exp_q);
        if (RELU) exp_q = '{9'h000, 9'h000, 9'h000, 9'h100};
        check_q("neg_sgn", q_s, exp_q);

        // Mixed-sign frame separating signed from unsigned ordering.
        do_reset();
        frame_q = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h10, 8'hFE, 8'h02,
                    8'h81, 8'h7E, 8'hC0, 8'h40, 8'h05, 8'h90, 8'h33, 8'hCC};
        send(0);
        exp_q = '{9'h080, 9'h0FF, 9'h090, 9'h1CC};
        check_q("mix_uns", q_u, exp_q);
        exp_q = '{9'h07F, 9'h002, 9'h07E, 9'h140};
        check_q("mix_sgn", q_s, exp_q);

        // Back-to-back frames.
        do_reset();
        frame_q.delete(); load_basic(); load_basic();
        chk_busy = 1'b1;
        send(0);
        chk_busy = 1'b0;
        exp_q = '{9'h005, 9'h009, 9'h008, 9'h1FF, 9'h005, 9'h009, 9'h008, 9'h1FF};
        check_q("b2b", q_u, exp_q);

        // Reset mid-frame after 6 accepted beats.
        do_reset();
        frame_q.delete(); load_basic();
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; in_data = frame_q[p];
            @(posedge clk);
        end
        do_reset();
        chk_reset_state();
        send(0);
        exp_q = '{9'h005, 9'h009, 9'h008, 9'h1FF};
        check_q("midrst", q_u, exp_q);

        // Randomized 12x12 run, 100 frames.
        @(negedge clk);
        rst_s = 1'b1; big_sel = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        q_b.delete(); frame_q.delete(); exp_q.delete();
        for (int k = 0; k < 100 * 144; k++) frame_q.push_back(8'($urandom));
        for (int f = 0; f < 100; f++) model(12, 12, f * 144);
        send(2);
        check_q("rand", q_b, exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
